// File: rtl/tick_sched_pkg.sv
// tick_sched_pkg: shared types for the tick scheduler.
// Holds FSM states, config request bundle and index check.
package tick_sched_pkg;

  localparam int REQ_CH_W  = 4;
  localparam int REQ_DIV_W = 32;

  typedef enum logic {
    IDLE,
    APPLY
  } sched_state_t;

  // Sized for the largest legal build (16 ch, 32-bit
  // divide); the top zero-extends into it.
  typedef struct packed {
    logic [REQ_CH_W-1:0]  channel;
    logic [REQ_DIV_W-1:0] divide;
    logic                 enable;
  } cfg_req_t;

  function automatic logic ch_invalid(
    input logic [REQ_CH_W-1:0] ch,
    input int                  n
  );
    return int'(ch) >= n;
  endfunction

endpackage

// File: rtl/tick_sched_if.sv
// tick_sched_if: valid/ready config port of the scheduler.
// master drives requests; slave returns ready and error.
interface tick_sched_if #(
  parameter int NUM_CH        = 4,
  parameter int COUNTER_WIDTH = 26
) ();
  import tick_sched_pkg::*;

  localparam int CH_W =
    (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic                     cfg_valid;
  logic                     cfg_ready;
  logic [CH_W-1:0]          cfg_channel;
  logic [COUNTER_WIDTH-1:0] cfg_divide;
  logic                     cfg_enable;
  logic                     cfg_error;

  modport master (
    output cfg_valid,
    output cfg_channel,
    output cfg_divide,
    output cfg_enable,
    input  cfg_ready,
    input  cfg_error
  );

  modport slave (
    input  cfg_valid,
    input  cfg_channel,
    input  cfg_divide,
    input  cfg_enable,
    output cfg_ready,
    output cfg_error
  );

endinterface

// File: rtl/tick_channel.sv
// tick_channel: one divider channel, 1-cycle tick + square.
// Ports: clk/rst, load_i/load_div_i/load_en_i, tick_o, square_o.
module tick_channel #(
  parameter int             W            = 26,
  parameter logic [W-1:0]   DEFAULT_DIV  = '0,
  parameter bit             RESET_ENABLE = 1'b1
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  input  logic         load_i,
  input  logic [W-1:0] load_div_i,
  input  logic         load_en_i,
  output logic         tick_o,
  output logic         square_o
);

  logic [W-1:0] cnt_q, cnt_d;
  logic [W-1:0] div_q, div_d;
  logic         en_q,  en_d;
  logic         tick_q, tick_d;
  logic         sq_q,  sq_d;

  // A load beats a coincident terminal count.
  always_comb begin
    cnt_d  = cnt_q;
    div_d  = div_q;
    en_d   = en_q;
    tick_d = 1'b0;
    sq_d   = sq_q;
    if (load_i) begin
      div_d = load_div_i;
      en_d  = load_en_i;
      cnt_d = '0;
      sq_d  = 1'b0;
    end else if (!en_q) begin
      cnt_d = '0;
      sq_d  = 1'b0;
    end else if (cnt_q == div_q) begin
      cnt_d  = '0;
      tick_d = 1'b1;
      sq_d   = ~sq_q;
    end else begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      cnt_q  <= '0;
      div_q  <= DEFAULT_DIV;
      en_q   <= RESET_ENABLE;
      tick_q <= 1'b0;
      sq_q   <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      div_q  <= div_d;
      en_q   <= en_d;
      tick_q <= tick_d;
      sq_q   <= sq_d;
    end
  end

  assign tick_o   = tick_q;
  assign square_o = sq_q;

endmodule

// File: rtl/tick_scheduler.sv
// tick_scheduler: NUM_CH divider channels + config FSM.
// Ports: input_clock, reset_n, cfg (slave), tick_out, square_out, busy.
module tick_scheduler
  import tick_sched_pkg::*;
#(
  parameter int NUM_CH        = 4,
  parameter int COUNTER_WIDTH = 26,
  parameter int DEFAULT_DIV   = 50_000_000,
  parameter bit RESET_ENABLE  = 1'b1
) (
  input  logic              input_clock,
  input  logic              reset_n,
  tick_sched_if.slave       cfg,
  output logic [NUM_CH-1:0] tick_out,
  output logic [NUM_CH-1:0] square_out,
  output logic              busy
);

  localparam logic [COUNTER_WIDTH-1:0] DEF_DIV =
    COUNTER_WIDTH'(DEFAULT_DIV);

  sched_state_t state_q;
  cfg_req_t     req_q, req_d;
  logic         ready_q;
  logic         busy_q;
  logic         err_q;
  logic         apply;
  logic         unused_div_bits;

  always_comb begin
    req_d         = '0;
    req_d.channel = REQ_CH_W'(cfg.cfg_channel);
    req_d.divide  = REQ_DIV_W'(cfg.cfg_divide);
    req_d.enable  = cfg.cfg_enable;
  end

  always_ff @(posedge input_clock) begin
    if (!reset_n) begin
      state_q <= IDLE;
      req_q   <= '0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (cfg.cfg_valid && ready_q) begin
            req_q   <= req_d;
            state_q <= APPLY;
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
          end
        end
        APPLY: begin
          err_q   <= ch_invalid(req_q.channel,
                                NUM_CH);
          state_q <= IDLE;
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign apply         = (state_q == APPLY);
  assign cfg.cfg_ready = ready_q;
  assign cfg.cfg_error = err_q;
  assign busy          = busy_q;

  // Upper divide bits are always zero by construction.
  assign unused_div_bits = ^req_q.divide;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    tick_channel #(
      .W            (COUNTER_WIDTH),
      .DEFAULT_DIV  (DEF_DIV),
      .RESET_ENABLE (RESET_ENABLE)
    ) u_ch (
      .clk_i      (input_clock),
      .rst_n_i    (reset_n),
      .load_i     (apply &&
                   (req_q.channel == REQ_CH_W'(i))),
      .load_div_i (req_q.divide[COUNTER_WIDTH-1:0]),
      .load_en_i  (req_q.enable),
      .tick_o     (tick_out[i]),
      .square_o   (square_out[i])
    );
  end

endmodule
